tns_cac_encoder_stream: RTL

- Parametrised successor of the fixed-width 31-bit Tribonacci-number-system crosstalk-avoidance encoder.
- Encodes a binary word into an NBITS-wide TNS codeword by greedy subtraction from the MSB down. Flexible bits reuse the value they had in the previous accepted codeword, to cut bus transitions.
- Adds three things over the fixed encoder:
  - width and flexibility mode as parameters;
  - valid/ready streaming with backpressure;
  - input range checking with saturation, and a history-clear control.
- Sits between a bus master's data register and the inter-die link driver.

---
 rtl/tns_cac_encoder_stream.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/tns_cac_encoder_stream.sv
// Tribonacci-number-system crosstalk-avoidance encoder with a valid/ready
// stream interface. A binary word is split greedily from the MSB down into
// Tribonacci weights. Bits that may take either value without losing the
// encoding reuse their value from the previous codeword, which cuts
// transitions on the bus.

package tns_cac_encoder_stream_pkg;

   // Tribonacci weight of bit i: 1, 1, 2, 4, 7, 13, 24, ...
   function automatic longint unsigned weight_f(input int i);
      longint unsigned a;
      longint unsigned b;
      longint unsigned c;
      longint unsigned n;
      a = 64'd0;
      b = 64'd0;
      c = 64'd1;
      for (int k = 1; k <= i; k++) begin
         n = a + b + c;
         a = b;
         b = c;
         c = n;
      end
      return c;
   endfunction

   // Sum of the weights of bits 0 .. n-1
   function automatic longint unsigned psum_f(input int n);
      longint unsigned s;
      s = 64'd0;
      for (int k = 0; k < n; k++) begin
         s = s + weight_f(k);
      end
      return s;
   endfunction

   // Width needed to carry any value from 0 up to the full codeword sum
   function automatic int dw_f(input int n);
      return $clog2(psum_f(n) + 64'd1);
   endfunction

endpackage

module tns_cac_encoder_stream #(
   parameter  int NBITS     = 31,
   parameter  int FLEX_MODE = 1,
   localparam int DW        = tns_cac_encoder_stream_pkg::dw_f(NBITS)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   input  logic             hist_clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NBITS-1:0] out_code,
   output logic             out_err
);

   import tns_cac_encoder_stream_pkg::*;

   typedef logic [NBITS-1:0][DW-1:0] tab_t;

   // Weight of each codeword bit
   function automatic tab_t w_tab_f();
      tab_t t;
      for (int i = 0; i < NBITS; i++) begin
         t[i] = DW'(weight_f(i));
      end
      return t;
   endfunction

   // Largest value the bits below bit i can still absorb
   function automatic tab_t s_tab_f();
      tab_t t;
      for (int i = 0; i < NBITS; i++) begin
         t[i] = DW'(psum_f(i));
      end
      return t;
   endfunction

   // Which bits may take their value from history
   function automatic logic [NBITS-1:0] flex_mask_f();
      logic [NBITS-1:0] m;
      for (int i = 0; i < NBITS; i++) begin
         case (FLEX_MODE)
            0:       m[i] = 1'b0;
            1:       m[i] = ((i % 3) == 2);
            2:       m[i] = (i != 0);
            default: m[i] = 1'b0;
         endcase
      end
      return m;
   endfunction

   localparam logic [DW-1:0]    S_TOTAL_DW = DW'(psum_f(NBITS));
   localparam tab_t             W_TAB      = w_tab_f();
   localparam tab_t             S_TAB      = s_tab_f();
   localparam logic [NBITS-1:0] FLEX_MASK  = flex_mask_f();

   logic             out_valid_r;
   logic [NBITS-1:0] out_code_r;
   logic             out_err_r;
   logic [NBITS-1:0] hist_r;

   logic             accept_s;
   logic             err_s;
   logic [DW-1:0]    v_s;
   logic [NBITS-1:0] hist_eff_s;
   logic [DW-1:0]    res_s;
   logic [NBITS-1:0] code_s;

   // Single output register: a new word enters whenever the register is
   // empty or being drained in the same cycle.
   assign in_ready  = !out_valid_r || out_ready;
   assign accept_s  = in_valid && in_ready;
   assign out_valid = out_valid_r;
   assign out_code  = out_code_r;
   assign out_err   = out_err_r;

   // Range check with saturation, and history seen by this word
   always_comb begin
      err_s = (in_data > S_TOTAL_DW);
      if (err_s) begin
         v_s = S_TOTAL_DW;
      end else begin
         v_s = in_data;
      end
      if (hist_clear) begin
         hist_eff_s = {NBITS{1'b0}};
      end else begin
         hist_eff_s = hist_r;
      end
   end

   // Greedy MSB-first encoding. A flexible bit is forced to 0 when its
   // weight does not fit, forced to 1 when the lower bits cannot absorb
   // the residual, and otherwise repeats its previous value.
   always_comb begin
      res_s  = v_s;
      code_s = {NBITS{1'b0}};
      for (int i = NBITS - 1; i >= 1; i--) begin
         if (FLEX_MASK[i]) begin
            if (res_s < W_TAB[i]) begin
               code_s[i] = 1'b0;
            end else if (res_s > S_TAB[i]) begin
               code_s[i] = 1'b1;
            end else begin
               code_s[i] = hist_eff_s[i];
            end
         end else begin
            code_s[i] = (res_s >= W_TAB[i]);
         end
         if (code_s[i]) begin
            res_s = res_s - W_TAB[i];
         end else begin
            res_s = res_s;
         end
      end
      // The residual left for bit 0 is always 0 or 1.
      code_s[0] = res_s[0];
   end

   // Output register, valid flag and flexible-bit history
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         out_valid_r <= 1'b0;
         out_code_r  <= {NBITS{1'b0}};
         out_err_r   <= 1'b0;
         hist_r      <= {NBITS{1'b0}};
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         out_code_r  <= code_s;
         out_err_r   <= err_s;
         hist_r      <= code_s;
      end else begin
         if (out_ready) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
         if (hist_clear) begin
            hist_r <= {NBITS{1'b0}};
         end else begin
            hist_r <= hist_r;
         end
      end
   end

endmodule
